// File: rtl/fpu_share_arbiter_pkg.sv
// Shared FPU definitions: operator encoding, idle operator,
// arbiter state type and the two-cycle operator set.
package fpu_share_arbiter_pkg;

    typedef enum logic [4:0] {
        _FADDS,
        _FSUBS,
        _FMULS,
        _FDIVS,
        _FSQRTS,
        _FSGNJS,
        _FSGNJNS,
        _FSGNJXS,
        _FMINS,
        _FMAXS,
        _FMADD,
        _FMSUB,
        _FNMADD,
        _FNMSUB,
        _FCVTWS,
        _FCVTSW
    } OPERATOR_t;

    // Single-cycle op that keeps the FPU cycle tracker parked.
    localparam OPERATOR_t FPU_NOP_OP = _FSGNJS;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } ARB_STATE_t;

    function automatic logic fpu_is_two_cycle(input OPERATOR_t op);
        case (op)
            _FADDS, _FSUBS,
            _FMADD, _FMSUB,
            _FNMADD, _FNMSUB: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Round-robin grant: priority starts one past the last grant
// and wraps; one-hot grant plus its index.
module fpu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_vld
);

    function automatic int wrap(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!o_vld && i_req[wrap(int'(i_last) + i)]) begin
                o_vld = 1'b1;
                o_gnt[wrap(int'(i_last) + i)] = 1'b1;
                o_idx = IDX_W'(wrap(int'(i_last) + i));
            end
        end
    end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one FPU among NUM_REQ requesters: round-robin issue,
// operands held through the FPU wait cycle, result returned to owner.
module fpu_share_arbiter
    import fpu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    input  OPERATOR_t          req_op_i    [NUM_REQ],
    input  logic [31:0]        req_opnd1_i [NUM_REQ],
    input  logic [31:0]        req_opnd2_i [NUM_REQ],
    input  logic [31:0]        req_opnd3_i [NUM_REQ],
    output logic [NUM_REQ-1:0] rsp_valid_o,
    input  logic [NUM_REQ-1:0] rsp_ready_i,
    output logic [31:0]        rsp_result_o,
    output OPERATOR_t          fpu_op_o,
    output logic [31:0]        fpu_operand1_o,
    output logic [31:0]        fpu_operand2_o,
    output logic [31:0]        fpu_operand3_o,
    input  logic [31:0]        fpu_result_i,
    input  logic               fpu_wait_i,
    output logic               busy_o
);

    ARB_STATE_t         r_state;
    ARB_STATE_t         w_next;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_gnt_vld;
    logic               w_rsp_done;
    logic               w_can_grant;
    logic               w_accept;
    OPERATOR_t          r_op;
    logic [31:0]        r_opnd1;
    logic [31:0]        r_opnd2;
    logic [31:0]        r_opnd3;
    logic [31:0]        r_result;

    fpu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req  (req_valid_i),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_vld  (w_gnt_vld)
    );

    // A new op may issue in the same cycle the previous response retires.
    assign w_rsp_done  = (r_state == RESP) && rsp_ready_i[r_owner];
    assign w_can_grant = (r_state == IDLE) || w_rsp_done;
    assign w_accept    = w_can_grant && w_gnt_vld;

    assign req_ready_o  = w_can_grant ? w_gnt : '0;
    assign rsp_valid_o  = (r_state == RESP) ? (NUM_REQ'(1) << r_owner) : '0;
    assign rsp_result_o = r_result;
    assign busy_o       = (r_state != IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = EXEC;
            EXEC: if (!fpu_wait_i) w_next = RESP;
            RESP: begin
                if (w_rsp_done) w_next = w_accept ? EXEC : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        fpu_op_o       = FPU_NOP_OP;
        fpu_operand1_o = '0;
        fpu_operand2_o = '0;
        fpu_operand3_o = '0;
        if (r_state == EXEC) begin
            fpu_op_o       = r_op;
            fpu_operand1_o = r_opnd1;
            fpu_operand2_o = r_opnd2;
            fpu_operand3_o = r_opnd3;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_last   <= IDX_W'(NUM_REQ - 1);
            r_owner  <= '0;
            r_op     <= FPU_NOP_OP;
            r_opnd1  <= '0;
            r_opnd2  <= '0;
            r_opnd3  <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_last  <= w_idx;
                r_owner <= w_idx;
                r_op    <= req_op_i[w_idx];
                r_opnd1 <= req_opnd1_i[w_idx];
                r_opnd2 <= req_opnd2_i[w_idx];
                r_opnd3 <= req_opnd3_i[w_idx];
            end
            if (r_state == EXEC && !fpu_wait_i) begin
                r_result <= fpu_result_i;
            end
        end
    end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed bench for fpu_share_arbiter with a small FPU model:
// two-cycle ops raise wait on their first cycle.
module tb_fpu_share_arbiter;
    import fpu_share_arbiter_pkg::*;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    OPERATOR_t     req_op [N];
    logic [31:0]   opa [N];
    logic [31:0]   opb [N];
    logic [31:0]   opc [N];
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready;
    logic [31:0]   rsp_result;
    OPERATOR_t     fpu_op;
    logic [31:0]   f1, f2, f3, fres;
    logic          fwait;
    logic          busy;
    logic          r_second;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int          r;
        OPERATOR_t   op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vt [6];

    always #5 clk = ~clk;

    fpu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_opnd1_i    (opa),
        .req_opnd2_i    (opb),
        .req_opnd3_i    (opc),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_result_o   (rsp_result),
        .fpu_op_o       (fpu_op),
        .fpu_operand1_o (f1),
        .fpu_operand2_o (f2),
        .fpu_operand3_o (f3),
        .fpu_result_i   (fres),
        .fpu_wait_i     (fwait),
        .busy_o         (busy)
    );

    function automatic logic [31:0] fake_fpu(input OPERATOR_t op,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] c);
        if (op == _FMULS && a == 32'h40400000 && b == 32'h40000000)
            return 32'h40C00000;
        if (op == _FADDS && a == 32'h3F800000 && b == 32'h40000000)
            return 32'h40400000;
        return a ^ b ^ c;
    endfunction

    // Result is garbage while wait is high.
    assign fwait = fpu_is_two_cycle(fpu_op) && !r_second;
    assign fres  = fwait ? 32'hDEADBEEF : fake_fpu(fpu_op, f1, f2, f3);

    always_ff @(posedge clk) begin
        if (rst) r_second <= 1'b0;
        else     r_second <= fwait;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_one(input int idx, input int r, input OPERATOR_t op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] res,
                           input int lat);
        int cyc;
        int l;
        @(posedge clk); #1;
        rsp_ready = '1;
        req_valid[r] = 1'b1;
        req_op[r] = op;
        opa[r] = a;
        opb[r] = b;
        opc[r] = c;
        cyc = 0;
        @(negedge clk);
        while (!req_ready[r] && cyc < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("vec%0d_grant", idx), 32'(req_ready), 32'(1) << r);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        l = 0;
        while (l < 20) begin
            @(negedge clk);
            l++;
            if (rsp_valid != '0) break;
            @(posedge clk); #1;
        end
        chk($sformatf("vec%0d_lat", idx), 32'(l), 32'(lat));
        chk($sformatf("vec%0d_owner", idx), 32'(rsp_valid), 32'(1) << r);
        chk($sformatf("vec%0d_result", idx), rsp_result, res);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gi;
        int ri;
        int l;
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            req_op[i] = _FSGNJS;
            opa[i] = '0;
            opb[i] = '0;
            opc[i] = '0;
        end

        vt[0] = '{0, _FMULS, 32'h40400000, 32'h40000000, 32'h0, 32'h40C00000, 2};
        vt[1] = '{2, _FADDS, 32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 3};
        vt[2] = '{1, _FSUBS, 32'h000000F0, 32'h0000000F, 32'h100, 32'h000001FF, 3};
        vt[3] = '{3, _FMINS, 32'h12340000, 32'h00005678, 32'h0, 32'h12345678, 2};
        vt[4] = '{3, _FMADD, 32'hFFFF0000, 32'h00FF00FF, 32'h1, 32'hFF0000FE, 3};
        vt[5] = '{0, _FSGNJS, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 32'hFFFFFFFF, 2};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset.
        chk("rst_result", rsp_result, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("idle_fpu_op", 32'(fpu_op), 32'(_FSGNJS));
            chk("idle_operands", f1 | f2 | f3, 32'h0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 6; i++) begin
            run_one(i, vt[i].r, vt[i].op, vt[i].a, vt[i].b, vt[i].c,
                    vt[i].res, vt[i].lat);
        end

        // Two-cycle op: operands stay put across the wait cycle.
        @(posedge clk); #1;
        req_valid[2] = 1'b1;
        req_op[2] = _FADDS;
        opa[2] = 32'h3F800000;
        opb[2] = 32'h40000000;
        opc[2] = 32'h0;
        @(negedge clk);
        chk("add_grant", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("add_n1_wait", 32'(fwait), 32'h1);
        chk("add_n1_op", 32'(fpu_op), 32'(_FADDS));
        chk("add_n1_opnd1", f1, 32'h3F800000);
        chk("add_n1_opnd2", f2, 32'h40000000);
        chk("add_n1_rsp", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("add_n2_wait", 32'(fwait), 32'h0);
        chk("add_n2_op", 32'(fpu_op), 32'(_FADDS));
        chk("add_n2_opnd1", f1, 32'h3F800000);
        chk("add_n2_opnd2", f2, 32'h40000000);
        chk("add_n2_rsp", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("add_n3_rsp", 32'(rsp_valid), 32'h4);
        chk("add_n3_result", rsp_result, 32'h40400000);
        @(posedge clk); #1;

        // Reset during EXEC of a fused op.
        req_valid[0] = 1'b1;
        req_op[0] = _FMADD;
        opa[0] = 32'h1;
        opb[0] = 32'h2;
        opc[0] = 32'h3;
        @(negedge clk);
        chk("mrst_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_exec_busy", 32'(busy), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_fpu_op", 32'(fpu_op), 32'(_FSGNJS));
        chk("mrst_operands", f1 | f2 | f3, 32'h0);
        for (int k = 0; k < 3; k++) begin
            chk("mrst_no_rsp", 32'(rsp_valid), 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        run_one(6, 1, _FMAXS, 32'h11, 32'h22, 32'h44, 32'h77, 2);

        // All requesters valid: grants rotate 0,1,2,3,...
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_op[i] = _FMINS;
            opa[i] = 32'h100 + 32'(i);
            opb[i] = '0;
            opc[i] = '0;
        end
        req_valid = '1;
        gi = 0;
        ri = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc == 17) req_valid = '0;
            @(negedge clk);
            if (req_ready != '0) begin
                chk("rr_grant", 32'(req_ready), 32'(1) << (gi % N));
                gi++;
            end
            if (rsp_valid != '0) begin
                chk("rr_owner", 32'(rsp_valid), 32'(1) << (ri % N));
                chk("rr_result", rsp_result, 32'h100 + 32'(ri % N));
                ri++;
            end
            @(posedge clk); #1;
        end
        chk("rr_grant_count", 32'(gi), 32'd9);
        chk("rr_rsp_count", 32'(ri), 32'd9);

        // Owner stalls the response; others wait.
        do_reset();
        req_valid[1] = 1'b1;
        req_op[1] = _FMINS;
        opa[1] = 32'h21;
        opb[1] = '0;
        opc[1] = '0;
        @(negedge clk);
        chk("stall_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = 4'b1001;
        opa[0] = 32'h30;
        opa[3] = 32'h33;
        rsp_ready = '0;
        @(negedge clk);
        chk("stall_exec_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'h2);
            chk("stall_result", rsp_result, 32'h21);
            chk("stall_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        chk("stall_release_grant", 32'(req_ready), 32'h8);
        chk("stall_release_rsp", 32'(rsp_valid), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = '1;
        l = 0;
        while (l < 20) begin
            @(negedge clk);
            l++;
            if (rsp_valid != '0) break;
            @(posedge clk); #1;
        end
        chk("stall_next_lat", 32'(l), 32'd2);
        chk("stall_next_owner", 32'(rsp_valid), 32'h8);
        chk("stall_next_result", rsp_result, 32'h33);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fpu_share_arbiter.md
# fpu_share_arbiter

Shares the single FPU instance between up to NUM_REQ requesters (scalar core plus vector lanes) with round-robin arbitration and valid/ready handshakes on both the request and the response side. It registers the granted operation and holds operands stable for the FPU's full latency, including the extra cycle signalled by the FPU wait output. It captures the result and returns it to the owning requester. It sits between the issue stages and the FPU and is the only block that drives FPU inputs.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ), width of the internal owner index.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high.
- req_op_i  in  NUM_REQ x OPERATOR_t  operation.
- req_opnd1_i, req_opnd2_i, req_opnd3_i  in  NUM_REQ x 32  operands.
- rsp_valid_o  out  NUM_REQ  one-hot result valid to the owner.
- rsp_ready_i  in  NUM_REQ  per-requester result accept.
- rsp_result_o  out  32  result, broadcast to all requesters; qualified by rsp_valid_o.
- fpu_op_o  out  OPERATOR_t  FPU operation.
- fpu_operand1_o, fpu_operand2_o, fpu_operand3_o  out  32  FPU operands.
- fpu_result_i  in  32  FPU result.
- fpu_wait_i  in  1  FPU wait output (high means the result is not final this cycle).
- busy_o  out  1  high whenever state is not IDLE.

## Operation
- State machine with three states: IDLE, EXEC, RESP.
- IDLE:
  - The arbiter grants the highest-priority valid requester and raises its req_ready_o in the same cycle (combinational from req_valid_i and the pointer).
  - On the handshake it registers op, operands and owner index, then goes to EXEC.
- EXEC:
  - The FPU ports are driven from the issue register.
  - When fpu_wait_i=0, the arbiter captures fpu_result_i into the result register and goes to RESP.
  - While fpu_wait_i=1 it stays in EXEC with all FPU inputs unchanged.
- RESP:
  - rsp_valid_o[owner]=1.
  - If rsp_ready_i[owner]=1, the response completes. In that same cycle the arbiter may grant a new request: a grant goes to EXEC, no grant goes to IDLE.
  - With no ready, it holds rsp_valid_o and rsp_result_o stable.
- Round-robin arbitration:
  - Pointer last_q holds the most recent grant. Priority starts at last_q+1 and wraps modulo NUM_REQ.
  - last_q updates only on a request handshake.
  - Reset value of last_q is NUM_REQ-1, so requester 0 has first priority.
- Idle FPU drive:
  - Outside EXEC, fpu_op_o is FPU_NOP_OP (_FSGNJS) with all operands 0.
  - This keeps the FPU's internal cycle tracker in its one-cycle state. The arbiter never presents a two-cycle op (add, sub, or the four fused ops) outside EXEC.
- Requests are never dropped or reordered. Exactly one op is in flight.
- The arbiter ignores req_valid_i on non-granted requesters. Those requesters must hold their request until they see req_ready_o.

## Timing
- Reset values: state IDLE, req_ready_o 0 until evaluated in IDLE, rsp_valid_o 0, rsp_result_o 0, fpu_op_o FPU_NOP_OP, operands 0, busy_o 0, last_q NUM_REQ-1.
- Reset mid-operation abandons the in-flight op without producing a response. The FPU shares rst_i, so both restart aligned.
- Single-cycle op:
  - Accept in cycle N.
  - EXEC in N+1, with fpu_wait_i=0.
  - rsp_valid_o in N+2.
- Two-cycle op (add/sub/fused):
  - Accept in N.
  - EXEC in N+1 with wait=1, and N+2 with wait=0.
  - rsp_valid_o in N+3.
- Back-to-back: a response handshake and a new accept may share a cycle. Sustained throughput is one single-cycle op every 2 cycles.
- Simultaneous requests: exactly one grant per cycle. The others wait for at least the current op's full latency.
- A requester that deasserts valid before ready is not granted and loses no state.
- The owner's rsp_ready_i held low stalls the arbiter indefinitely in RESP. No requester is accepted meanwhile.

## Structure
- Shared FPU package holds:
  - the existing OPERATOR_t,
  - the new constant FPU_NOP_OP,
  - the state typedef ARB_STATE_t {IDLE, EXEC, RESP},
  - a function fpu_is_two_cycle(OPERATOR_t), so the FPU and all users share one definition of the two-cycle op set.
- Sub-module fpu_rr_arbiter contains the pure round-robin grant logic (request vector plus pointer in, one-hot grant plus index out). It is reusable by other shared units.

## Test plan
- Reset, no requests -> busy_o=0, rsp_valid_o=0, fpu_op_o=_FSGNJS, operands 0 for 10 cycles.
- Req0 issues _FMULS 3.0 (0x40400000) x 2.0 (0x40000000), accepted in cycle N -> rsp_valid_o=0001 in N+2 with rsp_result_o=0x40C00000.
- Req2 issues _FADDS 1.0+2.0 -> fpu_wait_i=1 at N+1, FPU inputs unchanged at N+2, rsp_valid_o=0100 at N+3 with result 0x40400000.
- All four requesters valid continuously, each with rsp_ready_i=1 -> grant order 0,1,2,3,0,…, each result routed only to its owner.
- Owner's rsp_ready_i held low for 5 cycles -> rsp_result_o stable, other requesters' req_ready_o stay 0, then the new grant lands on the handshake cycle.
- rst_i asserted during EXEC of an _FMADD -> next cycle state IDLE, no rsp_valid_o, fpu_op_o=_FSGNJS, and the next request completes normally.
